// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw push-button pins in, debounced level and press/release strobes out
interface key_conditioner_if #(parameter int NUM_KEYS = 2);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_down;
    logic [NUM_KEYS-1:0] key_up;
    logic [NUM_KEYS-1:0] key_long;
    modport master (output key_raw, input key_level, key_down, key_up, key_long);
    modport slave (input key_raw, output key_level, key_down, key_up, key_long);
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer and press/release pulse generator.
// Define KEY_AUTOREPEAT_EN to compile in the hold timeout and auto-repeat pulses.
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int HOLD_CYCLES     = 65536,
    parameter int REPEAT_CYCLES   = 16384
) (
    input  logic             clock,
    input  logic             reset,
    key_conditioner_if.slave keys
);
`ifdef KEY_AUTOREPEAT_EN
    localparam int MAX_A      = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
`else
    localparam int MAX_CYCLES = DEBOUNCE_CYCLES;
`endif
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
`ifdef KEY_AUTOREPEAT_EN
        REPEAT       = 3'd3,
`endif
        RELEASE_WAIT = 3'd4
    } state_t;

    logic [NUM_KEYS-1:0] w_level, w_down, w_up, w_long;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [1:0]    r_sync;
        state_t        r_state, w_state_nx;
        logic [CW-1:0] r_cnt, w_cnt_nx;
        logic          r_level, r_down, r_up, r_long;
        logic          w_down_nx, w_up_nx, w_in;

        assign w_in = r_sync[1];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_sync  <= '0;
                r_state <= IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_down  <= 1'b0;
                r_up    <= 1'b0;
                r_long  <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], keys.key_raw[k]};
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_level <= (w_state_nx != IDLE) && (w_state_nx != PRESS_WAIT);
                r_down  <= w_down_nx;
                r_up    <= w_up_nx;
`ifdef KEY_AUTOREPEAT_EN
                r_long  <= (w_state_nx == REPEAT);
`else
                r_long  <= 1'b0;
`endif
            end
        end

        // Every exit from a counting state clears the counter, so it never passes its terminal count.
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt + 1'b1;
            w_down_nx  = 1'b0;
            w_up_nx    = 1'b0;
            case (r_state)
                IDLE: begin
                    w_cnt_nx = '0;
                    if (w_in) w_state_nx = PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (!w_in) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nx = HELD;
                        w_down_nx  = 1'b1;
                        w_cnt_nx   = '0;
                    end
                end
                HELD: begin
`ifdef KEY_AUTOREPEAT_EN
                    if (!w_in) begin
                        w_state_nx = RELEASE_WAIT;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_state_nx = REPEAT;
                        w_down_nx  = 1'b1;
                        w_cnt_nx   = '0;
                    end
`else
                    w_cnt_nx = '0;
                    if (!w_in) w_state_nx = RELEASE_WAIT;
`endif
                end
`ifdef KEY_AUTOREPEAT_EN
                REPEAT: begin
                    if (!w_in) begin
                        w_state_nx = RELEASE_WAIT;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == REP_LAST) begin
                        w_down_nx = 1'b1;
                        w_cnt_nx  = '0;
                    end
                end
`endif
                RELEASE_WAIT: begin
                    if (w_in) begin
                        w_state_nx = HELD;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nx = IDLE;
                        w_up_nx    = 1'b1;
                        w_cnt_nx   = '0;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end

        assign w_level[k] = r_level;
        assign w_down[k]  = r_down;
        assign w_up[k]    = r_up;
        assign w_long[k]  = r_long;
    end

    assign keys.key_level = w_level;
    assign keys.key_down  = w_down;
    assign keys.key_up    = w_up;
    assign keys.key_long  = w_long;
endmodule
